// File: rtl/div4_seq_ctrl_pkg.sv
// rtl/div4_seq_ctrl_pkg.sv - shared types and constants for the sequential restoring divider
package div4_seq_ctrl_pkg;

  // Default operand width; iteration count equals the width.
  localparam int DIV_W = 4;

  // Iteration counter is wide enough to hold the value W itself.
  localparam int CNT_W = $clog2(DIV_W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Trial value for one restoring step: partial remainder shifted left with
  // the next dividend bit brought in at the bottom.
  function automatic logic [DIV_W-1:0] trial_value(input logic [DIV_W-1:0] r,
                                                   input logic [DIV_W-1:0] q);
    return {r[DIV_W-2:0], q[DIV_W-1]};
  endfunction

endpackage

// File: rtl/div4_seq_ctrl.sv
// rtl/div4_seq_ctrl.sv - sequential restoring divider controller driving an external subtractor
module div4_seq_ctrl
  import div4_seq_ctrl_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [W-1:0] sub_a,
  output logic [W-1:0] sub_b,
  input  logic [W-1:0] sub_diff,
  input  logic         sub_carry
);

  state_t             state;
  state_t             state_next;

  logic [W-1:0]       r_reg;
  logic [W-1:0]       q_reg;
  logic [W-1:0]       d_reg;
  logic [CNT_W-1:0]   cnt;

  logic [W-1:0]       trial;
  logic [W-1:0]       r_step;
  logic [W-1:0]       q_step;
  logic               last_iter;

  // One restoring step: keep the difference when the trial covers the divisor.
  always_comb begin
    trial     = trial_value(r_reg, q_reg);
    r_step    = sub_carry ? sub_diff : trial;
    q_step    = {q_reg[W-2:0], sub_carry};
    last_iter = (cnt == CNT_W'(W - 1));
  end

  // Subtractor operands: the trial value while iterating, otherwise a stable R/D view.
  always_comb begin
    sub_b = d_reg;
    if (state == ITER) begin
      sub_a = trial;
    end else begin
      sub_a = r_reg;
    end
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Working registers and result registers; results hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_reg       <= divisor;
            q_reg       <= dividend;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        ITER: begin
          r_reg <= r_step;
          q_reg <= q_step;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quotient  <= q_step;
            remainder <= r_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div4_seq_ctrl.sv
// tb/tb_div4_seq_ctrl.sv - self-checking bench for the sequential restoring divider
module tb_div4_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;
  logic [3:0] sub_a;
  logic [3:0] sub_b;
  logic [3:0] sub_diff;
  logic       sub_carry;

  int n_cmp;
  int n_fail;

  div4_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_diff   (sub_diff),
    .sub_carry  (sub_carry)
  );

  // Behavioural ripple subtractor beside the controller.
  assign sub_diff  = sub_a - sub_b;
  assign sub_carry = (sub_a >= sub_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] dd;
    logic [3:0] dv;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Issue one start and check timing, results and the single done pulse.
  task automatic run_op(input logic [3:0] dd, input logic [3:0] dv,
                        input int eq, input int er, input int edbz, input int elat,
                        input string tag);
    int lat;
    int seen;
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      chk({tag, ".busy_iter"}, int'(busy), 1);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".done_seen"}, seen, 1);
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".quotient"}, int'(quotient), eq);
    chk({tag, ".remainder"}, int'(remainder), er);
    chk({tag, ".div_by_zero"}, int'(div_by_zero), edbz);
    chk({tag, ".busy_done"}, int'(busy), 1);
    @(posedge clk);
    #1;
    chk({tag, ".done_single"}, int'(done), 0);
    chk({tag, ".busy_idle"}, int'(busy), 0);
  endtask

  task automatic run_model(input logic [3:0] dd, input logic [3:0] dv, input string tag);
    int eq, er, edbz, elat;
    if (dv == 0) begin
      eq = 15; er = int'(dd); edbz = 1; elat = 0;
    end else begin
      eq = int'(dd) / int'(dv); er = int'(dd) % int'(dv); edbz = 0; elat = 4;
    end
    run_op(dd, dv, eq, er, edbz, elat, tag);
  endtask

  initial begin
    int rounds;
    n_cmp    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0] = '{dd: 4'd13, dv: 4'd3,  q: 4'd4,  r: 4'd1, dbz: 1'b0, lat: 4};
    vecs[1] = '{dd: 4'd15, dv: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0, lat: 4};
    vecs[2] = '{dd: 4'd2,  dv: 4'd9,  q: 4'd0,  r: 4'd2, dbz: 1'b0, lat: 4};
    vecs[3] = '{dd: 4'd15, dv: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0, lat: 4};
    vecs[4] = '{dd: 4'd7,  dv: 4'd0,  q: 4'd15, r: 4'd7, dbz: 1'b1, lat: 0};
    vecs[5] = '{dd: 4'd9,  dv: 4'd4,  q: 4'd2,  r: 4'd1, dbz: 1'b0, lat: 4};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    chk("reset.quotient", int'(quotient), 0);
    chk("reset.remainder", int'(remainder), 0);
    chk("reset.div_by_zero", int'(div_by_zero), 0);
    chk("reset.sub_a", int'(sub_a), 0);
    chk("reset.sub_b", int'(sub_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, int'(vecs[i].q), int'(vecs[i].r),
             int'(vecs[i].dbz), vecs[i].lat, $sformatf("vec%0d", i));
    end

    // start held high; operands change during the second iteration
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("held.done1", int'(done), 1);
    chk("held.quotient1", int'(quotient), 2);
    chk("held.remainder1", int'(remainder), 2);
    @(posedge clk);
    #1;
    chk("held.idle_busy", int'(busy), 0);
    chk("held.idle_done", int'(done), 0);
    @(posedge clk);
    #1;
    chk("held.restart_busy", int'(busy), 1);
    chk("held.restart_done", int'(done), 0);
    repeat (4) @(posedge clk);
    #1;
    chk("held.done2", int'(done), 1);
    chk("held.quotient2", int'(quotient), 3);
    chk("held.remainder2", int'(remainder), 0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);

    // reset in the third iteration cycle aborts with no done pulse
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.quotient", int'(quotient), 0);
    chk("abort.remainder", int'(remainder), 0);
    chk("abort.div_by_zero", int'(div_by_zero), 0);
    chk("abort.sub_a", int'(sub_a), 0);
    chk("abort.sub_b", int'(sub_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort.no_done", int'(done), 0);
    end
    run_op(4'd11, 4'd2, 5, 1, 0, 4, "abort.fresh");

    // exhaustive sweep against integer division
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_model(4'(a), 4'(b), $sformatf("sweep_%0d_%0d", a, b));
      end
    end

    // randomized operands with random idle gaps
    rounds = 150;
    for (int i = 0; i < rounds; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_model(ra, rb, $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
